// File: rtl/moving_average_n_pkg.sv
// Purpose: shared types, rounding constants and the divide-by-shift helper for
//          the moving_average_n filter.
// Contents: sample_t/acc_t/ptr_t (default configuration), ROUND_* mode codes,
//           avg_shift() which divides a wide signed sum by 2**shift.
package moving_average_n_types;

  // Default configuration; parameterised modules size their own signals.
  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_WIN_LOG2 = 2;

  // Wide container that holds any legal window sum with headroom.
  localparam int unsigned WIDE_W = 64;

  localparam int unsigned ROUND_FLOOR   = 0;
  localparam int unsigned ROUND_HALF_UP = 1;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic signed [WIDE_W-1:0]     acc_t;
  typedef logic [DEF_WIN_LOG2-1:0]      ptr_t;

  // Divide by 2**shift; half-up mode biases by half an LSB of the result first.
  function automatic acc_t avg_shift(input acc_t sum, input int unsigned mode,
                                     input int unsigned shift);
    acc_t bias;
    bias = '0;
    if (mode == ROUND_HALF_UP) bias = acc_t'(1) <<< (shift - 1);
    return (sum + bias) >>> shift;
  endfunction

endpackage

// File: rtl/moving_average_ring.sv
// Purpose: N-entry sample store with a wrapping write pointer. The entry about
//          to be overwritten (the oldest sample) is presented combinationally.
// Ports:
//   clk_i       clock
//   rst_i       synchronous reset, active-high (zero-fills, pointer to 0)
//   clear_i     synchronous flush, same effect as reset
//   wr_en_i     store wr_data_i at the write pointer and advance it
//   wr_data_i   sample to store
//   oldest_c_o  entry at the write pointer (combinational)
module moving_average_ring #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WIN_LOG2 = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] oldest_c_o
);

  localparam int unsigned N = 1 << WIN_LOG2;

  logic [DATA_W-1:0]   mem_q [N];
  logic [WIN_LOG2-1:0] wp_q;
  logic [WIN_LOG2-1:0] wp_d;

  assign oldest_c_o = mem_q[wp_q];

  // Power-of-two depth: the pointer wraps N-1 -> 0 by natural overflow.
  always_comb begin
    wp_d = wp_q;
    if (clear_i)      wp_d = '0;
    else if (wr_en_i) wp_d = wp_q + WIN_LOG2'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
    end else begin
      if (wr_en_i) mem_q[wp_q] <= wr_data_i;
      wp_q <= wp_d;
    end
  end

endmodule

// File: rtl/moving_average_n.sv
// Purpose: streaming moving average over the last 2**WIN_LOG2 signed samples,
//          divided by shift with floor or round-half-up, one-cycle latency.
// Ports:
//   system1000      clock
//   system1000_rst  synchronous reset, active-high
//   clear           synchronous window flush (lower priority than reset)
//   in_valid        in_data carries a new sample
//   in_data         signed sample
//   out_valid       out_data carries a new average
//   out_data        signed average of the window (vacant slots count as zero)
//   out_full        a full window has been accepted since last reset/clear
module moving_average_n
  import moving_average_n_types::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned WIN_LOG2   = 2,
  parameter int unsigned ROUND_MODE = ROUND_FLOOR
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_full
);

  localparam int unsigned N      = 1 << WIN_LOG2;
  localparam int unsigned SUM_W  = DATA_W + WIN_LOG2 + 1;
  localparam int unsigned FILL_W = WIN_LOG2 + 1;

  logic                    accept_c;
  logic [DATA_W-1:0]       oldest_c;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic                    valid_q, valid_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    full_q, full_d;

  // A sample concurrent with clear is discarded.
  assign accept_c = in_valid & ~clear;

  moving_average_ring #(
    .DATA_W   (DATA_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_ring (
    .clk_i      (system1000),
    .rst_i      (system1000_rst),
    .clear_i    (clear),
    .wr_en_i    (accept_c),
    .wr_data_i  (in_data),
    .oldest_c_o (oldest_c)
  );

  // Running sum: add the new sample, retire the one it overwrites.
  always_comb begin
    sum_d   = sum_q;
    fill_d  = fill_q;
    valid_d = 1'b0;
    data_d  = data_q;
    full_d  = full_q;
    if (clear) begin
      sum_d  = '0;
      fill_d = '0;
      data_d = '0;
      full_d = 1'b0;
    end else if (in_valid) begin
      sum_d = sum_q + SUM_W'(signed'(in_data)) - SUM_W'(signed'(oldest_c));
      if (fill_q != FILL_W'(N)) fill_d = fill_q + FILL_W'(1);
      valid_d = 1'b1;
      data_d  = DATA_W'(avg_shift(WIDE_W'(sum_d), ROUND_MODE, WIN_LOG2));
      full_d  = (fill_d == FILL_W'(N));
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      sum_q   <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      full_q  <= full_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_full  = full_q;

endmodule

// File: tb/tb_moving_average_n.sv
// Scoreboard bench: two instances (floor and round-half-up, N=4, 8-bit) share
// clock, reset, clear and data; each has its own in_valid and expect queue.
module tb_moving_average_n;

  typedef struct {
    int d;
    bit f;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       v0 = 1'b0;
  logic       v1 = 1'b0;
  logic [7:0] din = '0;
  logic       ov0, ov1, of0, of1;
  logic [7:0] od0, od1;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad = 0;
  int   flush_seq = 0;
  bit   armed = 1'b0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  moving_average_n #(.DATA_W(8), .WIN_LOG2(2), .ROUND_MODE(0)) u_floor (
    .system1000     (clk),
    .system1000_rst (rst),
    .clear          (clr),
    .in_valid       (v0),
    .in_data        (din),
    .out_valid      (ov0),
    .out_data       (od0),
    .out_full       (of0)
  );

  moving_average_n #(.DATA_W(8), .WIN_LOG2(2), .ROUND_MODE(1)) u_round (
    .system1000     (clk),
    .system1000_rst (rst),
    .clear          (clr),
    .in_valid       (v1),
    .in_data        (din),
    .out_valid      (ov1),
    .out_data       (od1),
    .out_full       (of1)
  );

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops on out_valid, otherwise checks that outputs are held.
  initial begin : monitor
    exp_t e;
    exp_t h0, h1;
    int   seen = 0;
    bit   fin = 1'b0;
    h0 = '{0, 1'b0};
    h1 = '{0, 1'b0};
    forever begin
      @(negedge clk);
      if (armed) begin
        if (flush_seq != seen) begin
          seen = flush_seq;
          h0 = '{0, 1'b0};
          h1 = '{0, 1'b0};
        end
        if (ov0) begin
          if (q0.size() == 0) cmp("floor_unexpected_valid", 1, 0);
          else begin
            e = q0.pop_front();
            cmp("floor_data", int'(signed'(od0)), e.d);
            cmp("floor_full", int'(of0), int'(e.f));
            h0 = e;
          end
        end else begin
          cmp("floor_hold_data", int'(signed'(od0)), h0.d);
          cmp("floor_hold_full", int'(of0), int'(h0.f));
        end
        if (ov1) begin
          if (q1.size() == 0) cmp("round_unexpected_valid", 1, 0);
          else begin
            e = q1.pop_front();
            cmp("round_data", int'(signed'(od1)), e.d);
            cmp("round_full", int'(of1), int'(e.f));
            h1 = e;
          end
        end else begin
          cmp("round_hold_data", int'(signed'(od1)), h1.d);
          cmp("round_hold_full", int'(of1), int'(h1.f));
        end
      end
      if (done && !fin) begin
        fin = 1'b1;
        cmp("floor_queue_drained", q0.size(), 0);
        cmp("round_queue_drained", q1.size(), 0);
      end
    end
  end

  // One sample; expectation pushed for each instance that sees in_valid.
  task automatic send(input int d, input int e0, input bit f0,
                      input bit use1 = 1'b0, input int e1 = 0, input bit f1 = 1'b0);
    din = 8'(d);
    v0  = 1'b1;
    v1  = use1;
    q0.push_back('{e0, f0});
    if (use1) q1.push_back('{e1, f1});
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset or clear, optionally with a concurrent sample that must be dropped.
  task automatic flush(input bit use_clear, input bit with_sample, input int d);
    if (use_clear) clr = 1'b1;
    else           rst = 1'b1;
    v0  = with_sample;
    v1  = with_sample;
    din = 8'(d);
    @(posedge clk);
    flush_seq++;
    #1;
    rst = 1'b0;
    clr = 1'b0;
    v0  = 1'b0;
    v1  = 1'b0;
  endtask

  initial begin : stimulus
    // Initial reset; monitor starts checking once state is defined.
    flush(1'b0, 1'b0, 0);
    armed = 1'b1;
    idle(2);

    // Ramp 4,8,12,16 then wrap with 20,24.
    send(4, 1, 1'b0);
    send(8, 3, 1'b0);
    send(12, 6, 1'b0);
    send(16, 10, 1'b1);
    send(20, 14, 1'b1);
    send(24, 18, 1'b1);
    idle(2);

    // Rounding on all -1 samples: floor vs half-up.
    flush(1'b0, 1'b0, 0);
    send(-1, -1, 1'b0, 1'b1, 0, 1'b0);
    send(-1, -1, 1'b0, 1'b1, 0, 1'b0);
    send(-1, -1, 1'b0, 1'b1, -1, 1'b0);
    send(-1, -1, 1'b1, 1'b1, -1, 1'b1);
    idle(2);

    // Extremes: 8x -128 then 8x 127.
    flush(1'b0, 1'b0, 0);
    send(-128, -32, 1'b0);
    send(-128, -64, 1'b0);
    send(-128, -96, 1'b0);
    for (int i = 0; i < 5; i++) send(-128, -128, 1'b1);
    send(127, -65, 1'b1);
    send(127, -1, 1'b1);
    send(127, 63, 1'b1);
    for (int i = 0; i < 5; i++) send(127, 127, 1'b1);
    idle(2);

    // Sparse samples, then clear with a concurrent sample.
    flush(1'b0, 1'b0, 0);
    send(3, 0, 1'b0);
    idle(2);
    send(6, 2, 1'b0);
    idle(2);
    send(9, 4, 1'b0);
    idle(2);
    flush(1'b1, 1'b1, 77);
    idle(1);
    send(8, 2, 1'b0);

    // Reset while an output is being presented, then restart.
    send(12, 5, 1'b0);
    flush(1'b0, 1'b1, 99);
    idle(1);
    send(4, 1, 1'b0);
    send(8, 3, 1'b0);
    send(12, 6, 1'b0);
    send(16, 10, 1'b1);
    idle(3);

    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
